// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: issue-side RAW/saturation scoreboard that also owns the register-file write port.
// Ports: clk, rst (sync, active-high); issue_valid/issue_rs/issue_rt/issue_rd/issue_wr in, stall out;
//        wb_valid/wb_addr/wb_data in; rf_write/rf_waddr/rf_wdata out to the register file;
//        ready out (block accepting issue); sb_err out (sticky protocol error, cleared by rst).
// Option: define REGFILE_SCOREBOARD_INIT_EN to zero registers 1..31 after reset before issue opens.
module regfile_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        rf_write,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ready,
  output logic        sb_err
);
  logic [31:0][CNT_W-1:0] cnt, cnt_nxt;
  logic inc_en, dec_en, same, underflow, wb_drop;
`ifdef REGFILE_SCOREBOARD_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [4:0] sweep;
  // ready is a registered copy of state==RUN so stall never sees a glitchy decode
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      sweep <= 5'd1;
      ready <= 1'b0;
    end else if (state == INIT) begin
      sweep <= sweep + 5'd1;
      if (sweep == 5'd31) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  assign rf_write = ready ? wb_valid : 1'b1;
  assign rf_waddr = ready ? wb_addr : sweep;
  assign rf_wdata = ready ? wb_data : 32'd0;
`else
  assign ready = 1'b1;
  assign rf_write = wb_valid;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;
`endif
  // hazards use start-of-cycle counts; a same-cycle writeback only releases next cycle
  assign stall = !ready || (issue_valid && (
                   (issue_rs != 5'd0 && cnt[issue_rs] != '0) ||
                   (issue_rt != 5'd0 && cnt[issue_rt] != '0) ||
                   (issue_wr && issue_rd != 5'd0 && cnt[issue_rd] == '1)));
  assign inc_en = issue_valid && !stall && issue_wr && issue_rd != 5'd0;
  assign dec_en = ready && wb_valid && wb_addr != 5'd0;
  assign same = inc_en && dec_en && issue_rd == wb_addr;
  assign underflow = dec_en && cnt[wb_addr] == '0;
  assign wb_drop = !ready && wb_valid;
  // an increment and decrement on the same register cancel; an orphan decrement floors at zero
  always_comb begin
    cnt_nxt = cnt;
    if (inc_en && !same) cnt_nxt[issue_rd] = cnt[issue_rd] + CNT_W'(1);
    if (dec_en && !same && !underflow) cnt_nxt[wb_addr] = cnt[wb_addr] - CNT_W'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sb_err <= sb_err | underflow | wb_drop;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed + random checks of regfile_scoreboard against a count-array model.
module tb_regfile_scoreboard;
  localparam int CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;
`ifdef REGFILE_SCOREBOARD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, iv, wr, wv;
  logic [4:0] rs, rt, rd, wa;
  logic [31:0] wd;
  logic stall, rf_write, ready, sb_err;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  int total = 0, bad = 0;
  int cnt_m[32];
  bit err_m, ready_m;
  int sweep_m;
  always #5 clk = ~clk;
  regfile_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs(rs), .issue_rt(rt), .issue_rd(rd),
    .issue_wr(wr), .stall(stall), .wb_valid(wv), .wb_addr(wa), .wb_data(wd),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ready(ready), .sb_err(sb_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input int s, input int t, input int d, input bit w,
                       input bit bv, input int ba, input logic [31:0] bd);
    iv = v; rs = 5'(s); rt = 5'(t); rd = 5'(d); wr = w; wv = bv; wa = 5'(ba); wd = bd;
  endtask
  function automatic bit exp_stall();
    if (!ready_m) return 1'b1;
    return iv && ((rs != 0 && cnt_m[rs] > 0) || (rt != 0 && cnt_m[rt] > 0) ||
                  (wr && rd != 0 && cnt_m[rd] == MAXC));
  endfunction
  task automatic model_reset();
    foreach (cnt_m[r]) cnt_m[r] = 0;
    err_m = 1'b0;
    ready_m = !INIT_EN;
    sweep_m = 1;
  endtask
  // check outputs against the model mid-cycle, then advance the model across the clock edge
  task automatic step(input string tag, input int es = -1);
    bit acc, inc, dec;
    #1;
    chk({tag, ".ready"}, ready, ready_m);
    chk({tag, ".stall"}, stall, exp_stall());
    chk({tag, ".sb_err"}, sb_err, err_m);
    if (es >= 0) chk({tag, ".stall_dir"}, stall, es);
    if (!ready_m) begin
      chk({tag, ".rf_write"}, rf_write, 1);
      chk({tag, ".rf_waddr"}, rf_waddr, sweep_m);
      chk({tag, ".rf_wdata"}, rf_wdata, 0);
    end else begin
      chk({tag, ".rf_write"}, rf_write, wv);
      if (wv) begin
        chk({tag, ".rf_waddr"}, rf_waddr, wa);
        chk({tag, ".rf_wdata"}, rf_wdata, wd);
      end
    end
    acc = iv && !exp_stall();
    @(posedge clk);
    if (rst) model_reset();
    else if (!ready_m) begin
      if (wv) err_m = 1'b1;
      sweep_m++;
      if (sweep_m == 32) ready_m = 1'b1;
    end else begin
      inc = acc && wr && rd != 0;
      dec = wv && wa != 0;
      if (dec && cnt_m[wa] == 0) err_m = 1'b1;
      if (!(inc && dec && rd == wa)) begin
        if (inc) cnt_m[rd]++;
        if (dec && cnt_m[wa] > 0) cnt_m[wa]--;
      end
    end
    #1;
  endtask
  task automatic drain();
    for (int r = 1; r < 32; r++)
      while (cnt_m[r] > 0) begin
        drive(0, 0, 0, 0, 0, 1, r, $urandom);
        step("drain");
      end
  endtask
  initial begin
    int pend[$];
    bit bv;
    int ba;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_reset();
    #1;
    step("rst1");
    step("rst2");
    rst = 1'b0;
`ifdef REGFILE_SCOREBOARD_INIT_EN
    for (int i = 1; i <= 31; i++) begin
      drive(i % 3 == 0, i, 0, 0, 0, 0, 0, 0);
      #1;
      chk("sweep_addr", rf_waddr, i);
      step("sweep", 1);
      chk("sweep_ready", ready, i == 31);
    end
`endif
    drive(1, 0, 0, 5, 1, 0, 0, 0); step("raw_issue", 0);
    drive(1, 5, 0, 0, 0, 0, 0, 0); step("raw_hazard", 1);
    drive(1, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    #1;
    chk("raw_wb_data", rf_wdata, 32'hDEADBEEF);
    step("raw_wb_same", 1);
    drive(1, 5, 0, 0, 0, 0, 0, 0); step("raw_release", 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 7, 1, 0, 0, 0); step("sat_fill", 0);
    end
    drive(1, 0, 0, 7, 1, 0, 0, 0); step("sat_full", 1);
    drive(1, 0, 0, 7, 1, 1, 7, 32'h7); step("sat_wb", 1);
    drive(1, 0, 0, 7, 1, 0, 0, 0); step("sat_accept", 0);
    drive(1, 0, 0, 9, 1, 0, 0, 0); step("sim_set", 0);
    drive(1, 0, 0, 9, 1, 1, 9, 32'h99); step("sim_both", 0);
    drive(1, 9, 0, 0, 0, 0, 0, 0); step("sim_hazard", 1);
    drive(0, 0, 0, 0, 0, 1, 9, 32'h9); step("sim_wb");
    drive(1, 0, 9, 0, 0, 0, 0, 0); step("sim_free", 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 0); step("r0", 0);
    end
    drive(1, 0, 0, 0, 1, 1, 0, 32'h1234); step("r0_wb", 0);
    chk("r0_err", sb_err, 0);
    drain();
    for (int n = 0; n < 400; n++) begin
      pend.delete();
      for (int r = 1; r < 32; r++) if (cnt_m[r] > 0) pend.push_back(r);
      bv = pend.size() > 0 && $urandom_range(0, 1) == 1;
      ba = bv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1) == 1, bv, ba, $urandom);
      step("rnd");
    end
    drain();
    drive(0, 0, 0, 0, 0, 1, 3, 32'h3); step("err_uf");
    chk("err_set", sb_err, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("err_hold");
    chk("err_sticky", sb_err, 1);
    drive(1, 0, 0, 7, 1, 0, 0, 0); step("pre_rst_issue", 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_b");
    rst = 1'b0;
    chk("rst_err_clr", sb_err, 0);
`ifdef REGFILE_SCOREBOARD_INIT_EN
    chk("rst_addr1", rf_waddr, 1);
    while (sweep_m < 12) step("resweep");
    chk("sweep12", rf_waddr, 12);
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    chk("restart_addr", rf_waddr, 1);
    chk("restart_ready", ready, 0);
    drive(0, 0, 0, 0, 0, 1, 4, 32'hABCD); step("init_wb");
    chk("init_wb_err", sb_err, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    while (!ready_m) step("sweep2");
`endif
    chk("post_rst_ready", ready, 1);
    drive(1, 7, 0, 0, 0, 0, 0, 0); step("rst_cnt_clr", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Issue-side controller for the 32×32 register file (one write port, two async read ports, register 0 hard-wired to zero). It tracks in-flight destination registers and stalls issue on RAW hazards and pending-count saturation. It owns the register file's write port: after reset it runs a zeroing sweep, then forwards writeback traffic. It sits between decode/issue and the register file, with the writeback stage as its second client.

## Interface
- CNT_W, default 2: width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_W − 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs, issue_rt  in  5  source register addresses.
- issue_rd  in  5  destination register address.
- issue_wr  in  1  instruction writes issue_rd.
- stall  out  1  issue must hold; instruction not accepted.
- wb_valid  in  1  writeback stage commits a result.
- wb_addr  in  5  writeback destination.
- wb_data  in  32  writeback value.
- rf_write, rf_waddr, rf_wdata  out  1/5/32  register-file write port.
- ready  out  1  sweep complete; block accepting issue.
- sb_err  out  1  sticky protocol-error flag.

## Operation
- State machine with two states:
  - INIT: zeroing sweep.
  - RUN: normal operation.
- INIT:
  - A 5-bit sweep counter starts at 1.
  - Each cycle drives rf_write=1, rf_waddr=counter, rf_wdata=0, then increments the counter.
  - After writing register 31, moves to RUN.
  - ready=0 and stall=1 throughout.
  - wb_valid in INIT is dropped and sets sb_err.
- RUN write port: rf_write=wb_valid, rf_waddr=wb_addr, rf_wdata=wb_data. This path is combinational, zero latency.
- Scoreboard: cnt[1..31], each CNT_W bits. Register 0 is never tracked and never stalls.
- Issue is accepted when issue_valid && !stall.
- stall (combinational) = !ready, OR issue_valid AND any of the following:
  - issue_rs≠0 and cnt[rs]≠0
  - issue_rt≠0 and cnt[rt]≠0
  - issue_wr and issue_rd≠0 and cnt[rd] is saturated
- On an accepted issue with issue_wr and rd≠0: cnt[rd]+1.
- On wb_valid with wb_addr≠0: cnt[wb_addr]−1.
  - If that count is already 0, the count stays 0 and sb_err is set.
  - wb_addr=0 is still forwarded to the register file but has no scoreboard effect.
- Accepted increment and writeback decrement to the same register in the same cycle leave the count unchanged.
- stall uses counts at the start of the cycle. A same-cycle writeback does not release a hazard; the release is visible the next cycle, when the register file already holds the new value.
- sb_err clears only on rst.

## Timing
- Reset values (at rst):
  - state=INIT (RUN when the macro is off); sweep counter=1; all cnt=0; sb_err=0.
  - ready=0 (1 when the macro is off); stall=1 (0 when the macro is off, given no hazard).
- Sweep: rst falls before edge E. Edges E..E+30 write registers 1..31. ready=1 from edge E+30 onward.
- rst asserted mid-sweep or mid-RUN:
  - Next edge restarts INIT at register 1 and clears all counts and sb_err.
  - In-flight writebacks after a reset are the pipeline's flush responsibility; orphan writebacks set sb_err.
- Counter updates take effect at the edge; stall and rf_* are combinational from current inputs and state.

## Configuration
- REGFILE_SCOREBOARD_INIT_EN:
  - Defined: INIT sweep as above; ready rises 31 cycles after reset release.
  - Undefined: INIT state and sweep counter are compiled out; block resets directly into RUN with ready=1, and rf_write follows wb_valid from the first cycle.

## Test plan
- Reset with macro: rst 2 cycles then release -> rf_write=1 with rf_waddr 1..31 and rf_wdata=0 on consecutive cycles; ready=1 after edge E+30; stall=1 until then.
- RAW hazard: issue rd=5 (wr=1) accepted. Next cycle issue rs=5 -> stall=1. wb_valid with wb_addr=5, wb_data=0xDEADBEEF -> that cycle stall stays 1; next cycle stall=0 and rf_write carried 0xDEADBEEF to register 5.
- Saturation with CNT_W=2: three accepted issues to rd=7 -> the fourth issue rd=7 stalls; one wb to register 7 -> the fourth issue is accepted the following cycle.
- Simultaneous: cnt[9]=1; same cycle an accepted issue rd=9 and wb_addr=9 -> cnt[9] stays 1; next issue rs=9 stalls.
- Register 0: issue rs=0, rt=0, rd=0 repeatedly -> never stalls. wb_addr=0 -> rf_write=1, no sb_err.
- Errors: wb_valid to register 3 with cnt[3]=0 -> sb_err=1 and stays 1 until rst. Assert rst mid-sweep at register 12 -> sweep restarts at register 1.
